// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, CP0 addresses, exception codes and the MEM->WB bus layout
package wb_stage_pkg;
  localparam int MS_TO_WS_BUS_WD = 86;
  localparam int STALL_BUS_WD = 10;
  localparam int FORWARD_BUS_WD = 33;
  localparam logic [7:0] CP0_COUNT = 8'h48;
  localparam logic [7:0] CP0_COMPARE = 8'h58;
  localparam logic [7:0] CP0_STATUS = 8'h60;
  localparam logic [7:0] CP0_CAUSE = 8'h68;
  localparam logic [7:0] CP0_EPC = 8'h70;
  localparam logic [4:0] EXCCODE_INT = 5'h00;
  localparam logic [4:0] EXCCODE_SYS = 5'h08;
  typedef struct packed {
    logic bd;
    logic exc_sys;
    logic eret;
    logic cp0_wen;
    logic res_from_cp0;
    logic [7:0] cp0_addr;
    logic [3:0] gr_we;
    logic [4:0] dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;
endpackage

// File: rtl/wb_cp0.sv
// wb_cp0: CP0 subset (Count, Compare, Status, Cause, EPC), timer and interrupt-pending logic
// ports: clk/resetn; write port wen/addr/wdata; exc/exc_code/eret strobes with bd/pc of the
// retiring instruction; ext_int level lines; rdata (combinational read), epc, int_pending
module wb_cp0
  import wb_stage_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        exc,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic        bd,
  input  logic [31:0] pc,
  input  logic [5:0]  ext_int,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_pending
);
  logic [31:0] count, compare, count_nx, status, cause;
  logic [7:0] im, ip;
  logic [4:0] exccode;
  logic exl, ie, bd_r, ti, tick, inc;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_count = wen && addr == CP0_COUNT;
  assign wr_compare = wen && addr == CP0_COMPARE;
  assign wr_status = wen && addr == CP0_STATUS;
  assign wr_cause = wen && addr == CP0_CAUSE;
  assign wr_epc = wen && addr == CP0_EPC;
  assign status = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign cause = {bd_r, ti, 14'd0, ip, 1'b0, exccode, 2'b00};
  assign inc = COUNT_DIV == 1 || tick;
  assign count_nx = wr_count ? wdata : count + {31'd0, inc};
  assign int_pending = |(ip & im) && ie && !exl;
  always_comb begin
    rdata = addr == CP0_COUNT   ? count   :
            addr == CP0_COMPARE ? compare :
            addr == CP0_STATUS  ? status  :
            addr == CP0_CAUSE   ? cause   :
            addr == CP0_EPC     ? epc     : 32'd0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      compare <= '0;
      tick <= 1'b0;
      im <= '0;
      ip <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd_r <= 1'b0;
      ti <= 1'b0;
      exccode <= '0;
      epc <= '0;
    end else begin
      tick <= ~tick;
      count <= count_nx;
      // IP7 carries the timer alongside ext_int[5]; IP1..0 are the software bits
      ip <= {ext_int[5] | ti, ext_int[4:0], wr_cause ? wdata[9:8] : ip[1:0]};
      // a match is only recognised when Count actually moves, so Count=Compare=0 out of reset stays quiet
      ti <= wr_compare ? 1'b0 : ((wr_count || inc) && count_nx == compare) ? 1'b1 : ti;
      if (wr_compare) compare <= wdata;
      if (wr_status) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (exc) begin
        exl <= 1'b1;
        exccode <= exc_code;
        if (!exl) begin
          epc <= bd ? pc - 32'd4 : pc;
          bd_r <= bd;
        end
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr_status) begin
        exl <= wdata[1];
      end
      if (wr_epc) epc <= wdata;
    end
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage; retires instructions, hosts CP0, raises flush/redirect on exceptions and ERET
// ports: clk/resetn; ms_to_ws_valid/ms_to_ws_bus in, ws_allowin out; ext_int; rf_we/rf_waddr/rf_wdata;
// stall_ws_bus/forward_ws_bus to ID; flush/flush_pc; debug_wb_* trace
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int COUNT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  input  logic [5:0]                 ext_int,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [STALL_BUS_WD-1:0]    stall_ws_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ws_bus,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);
  ms_to_ws_t ws;
  logic ws_valid, ws_ready_go, exc, eret_taken, int_pending;
  logic [31:0] cp0_rdata, epc;
  assign ws_ready_go = 1'b1;
  assign ws_allowin = !ws_valid || ws_ready_go;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws <= '0;
    end else if (ws_allowin) begin
      ws_valid <= !flush && ms_to_ws_valid;
      if (ms_to_ws_valid) ws <= ms_to_ws_bus;
    end
  end
  assign exc = ws_valid && (int_pending || ws.exc_sys);
  assign eret_taken = ws_valid && ws.eret && !exc;
  assign flush = exc || eret_taken;
  assign flush_pc = eret_taken ? epc : EXC_VECTOR;
  assign rf_we = {4{ws_valid && !flush}} & ws.gr_we;
  assign rf_waddr = ws.dest;
  assign rf_wdata = ws.res_from_cp0 ? cp0_rdata : ws.result;
  assign stall_ws_bus = {ws_valid && |ws.gr_we, rf_we, ws.dest};
  assign forward_ws_bus = {ws_valid, rf_wdata};
  assign debug_wb_pc = ws.pc;
  assign debug_wb_rf_wen = rf_we;
  assign debug_wb_rf_wnum = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  // MTC0 carries its source operand in the result field
  wb_cp0 #(.COUNT_DIV(COUNT_DIV)) u_cp0 (
    .clk        (clk),
    .resetn     (resetn),
    .wen        (ws_valid && ws.cp0_wen && !exc),
    .addr       (ws.cp0_addr),
    .wdata      (ws.result),
    .exc        (exc),
    .exc_code   (int_pending ? EXCCODE_INT : EXCCODE_SYS),
    .eret       (eret_taken),
    .bd         (ws.bd),
    .pc         (ws.pc),
    .ext_int    (ext_int),
    .rdata      (cp0_rdata),
    .epc        (epc),
    .int_pending(int_pending)
  );
endmodule
